// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the REF_CLK command sequencer: command bytes,
// FSM states and the fixed RegFile slots that hold the ALU operands.
package sys_pkg;

    localparam logic [7:0] CMD_RF_WR     = 8'hAA;
    localparam logic [7:0] CMD_RF_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_W_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NO_OP = 8'hDD;

    localparam logic [3:0] OPA_ADDR = 4'h0;
    localparam logic [3:0] OPB_ADDR = 4'h1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        ALU_FUNC,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

    // States that are waiting for the next byte of a frame from the host.
    function automatic logic is_frame_state(input state_t s);
        return s inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUNC};
    endfunction

endpackage

// File: rtl/sys_ctrl_if.sv
// Bus bundle between sys_ctrl (master) and the RX sync / RegFile / ALU /
// TX FIFO side (slave).
interface sys_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [ADDR_WIDTH-1:0]   RF_ADDR;
    logic                    RF_WR_EN;
    logic                    RF_RD_EN;
    logic [DATA_WIDTH-1:0]   RF_WR_DATA;
    logic [DATA_WIDTH-1:0]   RF_RD_DATA;
    logic                    RF_RD_VLD;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic                    ALU_EN;
    logic                    ALU_CLK_EN;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VLD;
    logic [DATA_WIDTH-1:0]   TX_WR_DATA;
    logic                    TX_WR_INC;
    logic                    TX_FIFO_FULL;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD,
               ALU_OUT, ALU_OUT_VLD, TX_FIFO_FULL,
        output RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA,
               ALU_FUN, ALU_EN, ALU_CLK_EN, TX_WR_DATA, TX_WR_INC
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD,
               ALU_OUT, ALU_OUT_VLD, TX_FIFO_FULL,
        input  RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA,
               ALU_FUN, ALU_EN, ALU_CLK_EN, TX_WR_DATA, TX_WR_INC
    );

endinterface

// File: rtl/sys_ctrl.sv
// UART command sequencer: decodes RX bytes into RegFile/ALU operations and
// pushes responses to the TX FIFO. SYS_CTRL_FRAME_TIMEOUT_EN enables the frame timeout.
module sys_ctrl
    import sys_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned FUN_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        REF_CLK,
    input  logic        RST_N,
    sys_ctrl_if.master  bus
);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [2*DATA_WIDTH-1:0] rsp_q;
    logic                    rsp_two_q;

    logic [ADDR_WIDTH-1:0]   rf_addr_q;
    logic                    rf_wr_en_q;
    logic                    rf_rd_en_q;
    logic [DATA_WIDTH-1:0]   rf_wr_data_q;
    logic [FUN_WIDTH-1:0]    alu_fun_q;
    logic                    alu_en_q;
    logic                    alu_clk_en_q;
    logic [DATA_WIDTH-1:0]   tx_wr_data_q;
    logic                    tx_wr_inc_q;

    logic                    timeout;

`ifdef SYS_CTRL_FRAME_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout = is_frame_state(state) && !bus.RX_D_VLD &&
                     (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N)
            to_cnt <= '0;
        else if (!is_frame_state(state) || bus.RX_D_VLD || timeout)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            wr_addr_q    <= '0;
            rsp_q        <= '0;
            rsp_two_q    <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_wr_data_q <= '0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            alu_clk_en_q <= 1'b0;
            tx_wr_data_q <= '0;
            tx_wr_inc_q  <= 1'b0;
        end else begin
            rf_wr_en_q  <= 1'b0;
            rf_rd_en_q  <= 1'b0;
            alu_en_q    <= 1'b0;
            tx_wr_inc_q <= 1'b0;

            if (timeout) begin
                state        <= IDLE;
                alu_clk_en_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.RX_D_VLD) begin
                        case (bus.RX_P_DATA)
                            CMD_RF_WR:     state <= WR_ADDR;
                            CMD_RF_RD:     state <= RD_ADDR;
                            CMD_ALU_W_OP:  state <= OPA;
                            CMD_ALU_NO_OP: begin
                                state        <= ALU_FUNC;
                                alu_clk_en_q <= 1'b1;
                            end
                            default:       state <= IDLE;
                        endcase
                    end
                    WR_ADDR: if (bus.RX_D_VLD) begin
                        wr_addr_q <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        state     <= WR_DATA;
                    end
                    WR_DATA: if (bus.RX_D_VLD) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_addr_q    <= wr_addr_q;
                        rf_wr_data_q <= bus.RX_P_DATA;
                        state        <= IDLE;
                    end
                    RD_ADDR: if (bus.RX_D_VLD) begin
                        rf_rd_en_q <= 1'b1;
                        rf_addr_q  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        state      <= RD_WAIT;
                    end
                    RD_WAIT: if (bus.RF_RD_VLD) begin
                        rsp_q     <= {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
                        rsp_two_q <= 1'b0;
                        state     <= TX_LO;
                    end
                    OPA: if (bus.RX_D_VLD) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_addr_q    <= ADDR_WIDTH'(OPA_ADDR);
                        rf_wr_data_q <= bus.RX_P_DATA;
                        state        <= OPB;
                    end
                    OPB: if (bus.RX_D_VLD) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_addr_q    <= ADDR_WIDTH'(OPB_ADDR);
                        rf_wr_data_q <= bus.RX_P_DATA;
                        alu_clk_en_q <= 1'b1;
                        state        <= ALU_FUNC;
                    end
                    ALU_FUNC: if (bus.RX_D_VLD) begin
                        alu_fun_q <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                        alu_en_q  <= 1'b1;
                        state     <= ALU_WAIT;
                    end
                    ALU_WAIT: if (bus.ALU_OUT_VLD) begin
                        rsp_q        <= bus.ALU_OUT;
                        rsp_two_q    <= 1'b1;
                        alu_clk_en_q <= 1'b0;
                        state        <= TX_LO;
                    end
                    // A full FIFO simply holds the TX state; rsp_q is untouched until popped out.
                    TX_LO: if (!bus.TX_FIFO_FULL) begin
                        tx_wr_data_q <= rsp_q[DATA_WIDTH-1:0];
                        tx_wr_inc_q  <= 1'b1;
                        state        <= rsp_two_q ? TX_HI : IDLE;
                    end
                    TX_HI: if (!bus.TX_FIFO_FULL) begin
                        tx_wr_data_q <= rsp_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        tx_wr_inc_q  <= 1'b1;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.RF_ADDR    = rf_addr_q;
    assign bus.RF_WR_EN   = rf_wr_en_q;
    assign bus.RF_RD_EN   = rf_rd_en_q;
    assign bus.RF_WR_DATA = rf_wr_data_q;
    assign bus.ALU_FUN    = alu_fun_q;
    assign bus.ALU_EN     = alu_en_q;
    assign bus.ALU_CLK_EN = alu_clk_en_q;
    assign bus.TX_WR_DATA = tx_wr_data_q;
    assign bus.TX_WR_INC  = tx_wr_inc_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: frames are issued with their expected strobes
// queued up front; a negedge monitor pops and compares as the DUT produces them.
module tb_sys_ctrl;
    import sys_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sys_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus();

    sys_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYC(100)
    ) dut (
        .REF_CLK(clk),
        .RST_N(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_tx[$];

    logic [7:0] ref_mem[16];
    logic [7:0] rf_mem[16];
    bit alu_frame_open = 1'b0;
    bit rand_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h expected no event", name, act);
    endtask

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        logic [15:0] aa, bb;
        aa = {8'h00, a};
        bb = {8'h00, b};
        case (f)
            4'd0:    return aa + bb;
            4'd1:    return aa - bb;
            4'd2:    return aa * bb;
            4'd3:    return aa & bb;
            4'd4:    return aa | bb;
            4'd5:    return aa ^ bb;
            default: return {a, b};
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [11:0] m_wr;
    logic [3:0]  m_nib;
    logic [7:0]  m_byte;
    bit          full_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.RF_WR_EN) begin
            chk("wr_rd_exclusive", {31'd0, bus.RF_RD_EN}, 32'd0);
            if (exp_wr.size() == 0) note_fail("unexpected_rf_wr", {20'd0, bus.RF_ADDR, bus.RF_WR_DATA});
            else begin
                m_wr = exp_wr.pop_front();
                chk("rf_wr", {20'd0, bus.RF_ADDR, bus.RF_WR_DATA}, {20'd0, m_wr});
            end
        end
        if (bus.RF_RD_EN) begin
            if (exp_rd.size() == 0) note_fail("unexpected_rf_rd", {28'd0, bus.RF_ADDR});
            else begin
                m_nib = exp_rd.pop_front();
                chk("rf_rd_addr", {28'd0, bus.RF_ADDR}, {28'd0, m_nib});
            end
        end
        if (bus.ALU_EN) begin
            chk("alu_clk_en_at_start", {31'd0, bus.ALU_CLK_EN}, 32'd1);
            if (exp_alu.size() == 0) note_fail("unexpected_alu_en", {28'd0, bus.ALU_FUN});
            else begin
                m_nib = exp_alu.pop_front();
                chk("alu_fun", {28'd0, bus.ALU_FUN}, {28'd0, m_nib});
            end
        end
        if (bus.ALU_OUT_VLD)
            chk("alu_clk_en_at_result", {31'd0, bus.ALU_CLK_EN}, 32'd1);
        if (bus.ALU_CLK_EN && !alu_frame_open)
            note_fail("alu_clk_en_stray", {31'd0, bus.ALU_CLK_EN});
        if (bus.TX_WR_INC) begin
            chk("tx_push_while_full", {31'd0, full_prev}, 32'd0);
            if (exp_tx.size() == 0) note_fail("unexpected_tx", {24'd0, bus.TX_WR_DATA});
            else begin
                m_byte = exp_tx.pop_front();
                chk("tx_data", {24'd0, bus.TX_WR_DATA}, {24'd0, m_byte});
            end
        end
        full_prev = bus.TX_FIFO_FULL;
    end

    // ---------------- RegFile and ALU responders ----------------
    initial begin : regfile_rsp
        logic [3:0] a;
        forever begin
            @(negedge clk);
            if (bus.RF_WR_EN) rf_mem[bus.RF_ADDR] = bus.RF_WR_DATA;
            if (bus.RF_RD_EN) begin
                a = bus.RF_ADDR;
                repeat ($urandom_range(3, 6)) @(posedge clk);
                #1 bus.RF_RD_DATA = rf_mem[a];
                bus.RF_RD_VLD = 1'b1;
                @(posedge clk);
                #1 bus.RF_RD_VLD = 1'b0;
                bus.RF_RD_DATA = 8'($urandom);
            end
        end
    end

    initial begin : alu_rsp
        logic [15:0] r;
        forever begin
            @(negedge clk);
            if (bus.ALU_EN) begin
                r = alu_model(rf_mem[0], rf_mem[1], bus.ALU_FUN);
                repeat ($urandom_range(3, 6)) @(posedge clk);
                #1 bus.ALU_OUT = r;
                bus.ALU_OUT_VLD = 1'b1;
                @(posedge clk);
                #1 bus.ALU_OUT_VLD = 1'b0;
                bus.ALU_OUT = 16'($urandom);
                alu_frame_open = 1'b0;
            end
        end
    end

    initial begin : full_driver
        forever begin
            @(posedge clk);
            #1;
            if (rand_full) bus.TX_FIFO_FULL = ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1 bus.RX_P_DATA = b;
        bus.RX_D_VLD = 1'b1;
        @(posedge clk);
        #1 bus.RX_D_VLD = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_alu.size() + exp_tx.size()) != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, (n >= 400)}, 32'd0);
        exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] d);
        exp_wr.push_back({ab[3:0], d});
        ref_mem[ab[3:0]] = d;
        send_byte(CMD_RF_WR, $urandom_range(0, 2));
        send_byte(ab, $urandom_range(0, 2));
        send_byte(d, 0);
        wait_idle("write");
    endtask

    // A stray command byte right after the last frame byte lands in a wait state and must vanish.
    task automatic do_read(input logic [7:0] ab, input bit junk);
        exp_rd.push_back(ab[3:0]);
        exp_tx.push_back(ref_mem[ab[3:0]]);
        send_byte(CMD_RF_RD, $urandom_range(0, 2));
        send_byte(ab, 0);
        if (junk) send_byte(CMD_RF_WR, 0);
        wait_idle("read");
    endtask

    task automatic issue_alu_noop(input logic [7:0] fb, input bit junk);
        logic [15:0] r;
        r = alu_model(ref_mem[0], ref_mem[1], fb[3:0]);
        exp_alu.push_back(fb[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        alu_frame_open = 1'b1;
        send_byte(CMD_ALU_NO_OP, $urandom_range(0, 2));
        send_byte(fb, 0);
        if (junk) send_byte(CMD_ALU_W_OP, 0);
    endtask

    task automatic do_alu_op(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] fb, input bit junk);
        logic [15:0] r;
        r = alu_model(a, b, fb[3:0]);
        ref_mem[0] = a;
        ref_mem[1] = b;
        exp_wr.push_back({OPA_ADDR, a});
        exp_wr.push_back({OPB_ADDR, b});
        exp_alu.push_back(fb[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        alu_frame_open = 1'b1;
        send_byte(CMD_ALU_W_OP, $urandom_range(0, 2));
        send_byte(a, $urandom_range(0, 2));
        send_byte(b, $urandom_range(0, 2));
        send_byte(fb, 0);
        if (junk) send_byte(CMD_RF_RD, 0);
        wait_idle("alu_op");
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rf_addr"},    {28'd0, bus.RF_ADDR}, 32'd0);
        chk({tag, "_rf_strobes"}, {30'd0, bus.RF_WR_EN, bus.RF_RD_EN}, 32'd0);
        chk({tag, "_rf_wr_data"}, {24'd0, bus.RF_WR_DATA}, 32'd0);
        chk({tag, "_alu"},        {26'd0, bus.ALU_FUN, bus.ALU_EN, bus.ALU_CLK_EN}, 32'd0);
        chk({tag, "_tx"},         {23'd0, bus.TX_WR_DATA, bus.TX_WR_INC}, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'h00;
            rf_mem[i] = 8'h00;
        end
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD = 1'b0;
        bus.RF_RD_DATA = '0;
        bus.RF_RD_VLD = 1'b0;
        bus.ALU_OUT = '0;
        bus.ALU_OUT_VLD = 1'b0;
        bus.TX_FIFO_FULL = 1'b0;

        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst_n = 1'b1;

        do_write(8'h04, 8'hAA);
        do_read(8'h04, 1'b0);
        do_alu_op(8'h05, 8'h06, 8'h00, 1'b0);
        do_alu_op(8'h6E, 8'h1D, 8'h00, 1'b0);

        @(posedge clk);
        #1 bus.TX_FIFO_FULL = 1'b1;
        issue_alu_noop(8'h02, 1'b0);
        repeat (20) @(posedge clk);
        chk("tx_held_while_full", exp_tx.size(), 32'd2);
        #1 bus.TX_FIFO_FULL = 1'b0;
        wait_idle("backpressure");

        send_byte(8'h55, 1);
        do_write(8'h03, 8'h77);

        send_byte(CMD_ALU_W_OP, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("mid_frame_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_write(8'h09, 8'h5A);
        do_read(8'h09, 1'b1);

`ifdef SYS_CTRL_FRAME_TIMEOUT_EN
        send_byte(CMD_RF_WR, 0);
        send_byte(8'h04, 0);
        repeat (105) @(posedge clk);
        do_read(8'h04, 1'b0);
`endif

        rand_full = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom), 1'($urandom));
                2: do_alu_op(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
                3: begin
                    issue_alu_noop(8'($urandom), 1'($urandom));
                    wait_idle("alu_noop");
                end
                default: begin
                    b = 8'($urandom);
                    while (b inside {CMD_RF_WR, CMD_RF_RD, CMD_ALU_W_OP, CMD_ALU_NO_OP})
                        b = 8'($urandom);
                    send_byte(b, 1);
                end
            endcase
        end
        rand_full = 1'b0;
        @(posedge clk);
        #1 bus.TX_FIFO_FULL = 1'b0;
        wait_idle("final");

        do_read(8'h00, 1'b0);
        do_read(8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
